// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer control stage that feeds the
// cascaded counter chain.
package timer_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } timer_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_ctrl_debouncer.sv
// Two-flop synchronizer plus level debouncer for one raw push-button;
// emits a one-cycle press pulse on each debounced rising edge.
module debouncer
   import timer_pkg::*;
#(
   parameter int DB_CYCLES = 3
) (
   input  logic ck,
   input  logic rst_s,
   input  logic btn,
   output logic press
);

   localparam int            CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          s1_q;
   logic          s2_q;
   logic          db_q;
   logic          db_d;
   logic          db_prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Debounced level only follows s2 after it has disagreed for DB_CYCLES edges.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge ck) begin
      if (rst_s) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         s1_q      <= btn;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
      end
   end

   assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/clear control for the counter chain: debounced buttons drive an
// IDLE/RUN/PAUSE machine, a RUN-only prescaler makes enb, and clr pulses once.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int DIV       = 4,
   parameter int DB_CYCLES = 3
) (
   input  logic               ck,
   input  logic               rst_s,
   input  logic               btn_ss,
   input  logic               btn_clr,
   output logic               enb,
   output logic               clr,
   output logic               running,
   output logic [STATE_W-1:0] state
);

   localparam int            PW       = cnt_width(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic         ss_press;
   logic         clr_press;
   timer_state_t state_q;
   timer_state_t state_d;
   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic         enb_q;
   logic         enb_d;
   logic         clr_q;
   logic         clr_d;
   logic         running_q;
   logic         running_d;

   debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .ck    (ck),
      .rst_s (rst_s),
      .btn   (btn_ss),
      .press (ss_press)
   );

   debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .ck    (ck),
      .rst_s (rst_s),
      .btn   (btn_clr),
      .press (clr_press)
   );

   // A clear press overrides a simultaneous start/stop press.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      if (clr_press) begin
         state_d = IDLE;
         clr_d   = 1'b1;
      end else if (ss_press) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Prescaler advances only on edges spent entirely in RUN; entry and pause
   // edges hold it so a resumed run finishes the interrupted period.
   always_comb begin
      pre_d = pre_q;
      enb_d = 1'b0;
      if (state_d == IDLE) begin
         pre_d = '0;
      end else if ((state_q == RUN) && (state_d == RUN)) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            enb_d = 1'b1;
         end else begin
            pre_d = pre_q + PRE_ONE;
         end
      end else begin
         pre_d = pre_q;
      end
      running_d = (state_d == RUN);
   end

   always_ff @(posedge ck) begin
      if (rst_s) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         enb_q     <= 1'b0;
         clr_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         enb_q     <= enb_d;
         clr_q     <= clr_d;
         running_q <= running_d;
      end
   end

   assign enb     = enb_q;
   assign clr     = clr_q;
   assign running = running_q;
   assign state   = state_q;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control stage that sits directly upstream of the cascaded `counter` chain and produces that chain's `enb` and `rst_s` inputs. It debounces two raw push-buttons (start/stop and clear) and runs a three-state IDLE/RUN/PAUSE machine. While running, a prescaler emits one-cycle count-enable ticks at 1/DIV of the clock rate; on clear it emits a one-cycle clear pulse to the counters. All logic updates on the rising edge of `ck`, so `enb`/`clr` are stable half a cycle before the counters sample them on the falling edge.

## Interface
- `DIV`, default 4: prescale ratio, ≥1; one `enb` tick per DIV cycles in RUN.
- `DB_CYCLES`, default 3: ≥1; consecutive cycles a synchronized button level must differ from the debounced level before the debounced level changes.
- `ck`  in  1  clock. Everything updates on the rising edge.
- `rst_s`  in  1  reset, synchronous, active-high.
- `btn_ss`  in  1  raw start/stop button, asynchronous, active-high.
- `btn_clr`  in  1  raw clear button, asynchronous, active-high.
- `enb`  out  1  registered count-enable tick to the counter chain.
- `clr`  out  1  registered one-cycle clear pulse, wired to the counters' `rst_s`.
- `running`  out  1  high while state is RUN.
- `state`  out  2  current state: IDLE=00, RUN=01, PAUSE=10.

## Operation
- Reset (rst_s high at an edge):
  - state=IDLE, prescaler=0, enb=0, clr=0, running=0.
  - Synchronizers, debounced levels and debounce counters all go to 0.
  - Reset has priority over every other event and aborts any debounce in progress.
- Button path, per button:
  - 2-flop synchronizer, then a debouncer.
  - Debouncer: `cnt` increments on each edge where the synchronized value s2 differs from the debounced level db.
  - When cnt==DB_CYCLES-1 and s2 still differs: db<=s2 and cnt<=0.
  - Whenever s2==db, cnt<=0. A glitch shorter than DB_CYCLES cycles is ignored.
  - Press event is the combinational rising edge of db (db high, previous db low). Release produces no event.
- FSM, evaluated on press events:
  - IDLE: ss → RUN. clr → stay IDLE and pulse clr.
  - RUN: ss → PAUSE. clr → IDLE and pulse clr.
  - PAUSE: ss → RUN. clr → IDLE and pulse clr.
  - Simultaneous ss and clr events: clr wins; ss is discarded.
- Prescaler (width $clog2(DIV), min 1):
  - Counts only in RUN. At each edge in RUN: if pre==DIV-1, then pre<=0 and enb<=1; otherwise pre<=pre+1 and enb<=0.
  - In PAUSE, pre holds its value and enb<=0. Resuming continues the partial period.
  - In IDLE, or on any clr event, pre<=0.
  - DIV=1: enb is high on every cycle in RUN, starting the cycle after entry.
- clr is high for exactly one cycle per clr event, asserted at the same edge as the state update.
- A button held through reset is seen as a fresh press once reset deasserts, because db resets to 0.

## Timing
- Raw button → state change:
  - Raw level first sampled at edge 0. s2 valid at edge 1.
  - db changes at edge 1+DB_CYCLES. State and clr update at edge 2+DB_CYCLES. With defaults, that is edge 5.
- RUN entry → first enb: state becomes RUN at edge E; enb is high in the cycle after edge E+DIV.
- Spacing: enb pulses are exactly DIV cycles apart while RUN is uninterrupted.
- Pause: the enb register clears at the edge where RUN→PAUSE. No enb occurs in the cycle after PAUSE entry.
- Counter interaction: enb and clr change only on rising edges. Downstream counters sample them at the next falling edge with half a cycle of setup.

## Structure
- Package `timer_pkg`: state typedef `timer_state_t` (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10) and the state-width constant.
- Sub-module `debouncer`, parameterized by DB_CYCLES: synchronizer, counter, db output and press pulse. Instantiate it twice.
- Top level: FSM, prescaler and output registers.

## Test plan
- Reset: assert rst_s for 2 cycles with both buttons high → all outputs 0. After release, ss press seen at edge 5 → state=01.
- Glitch reject, defaults: btn_ss high for 2 cycles then low → state stays 00, no clr.
- Run ticks, DIV=4: one ss press → enb high 4 cycles after RUN entry, then every 4 cycles. Check 5 consecutive ticks.
- Pause/resume, DIV=4: pause when pre==2 → no enb while paused. Resume → next enb 2 cycles after re-entering RUN.
- Clear from RUN, then simultaneous ss+clr presses from PAUSE → each time one clr cycle, state=00, pre=0, no RUN entry.
- DIV=1 and DB_CYCLES=1 corner: ss press → state change at edge 3; enb high every cycle in RUN.
